sweep_ctrl: RTL and testbench

//  Consumes the 0.5Hz square wave from the slow clock divider and uses each rising

---
 rtl/sweep_ctrl.sv | 118 +++++++++++
 tb/tb_sweep_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// DDS sweep controller: turns rising edges of the slow tick into steps of the
// frequency tuning word, in up-wrap, down-wrap, triangle or hold mode.
module sweep_ctrl #(
    parameter int               FTW_W    = 32,
    parameter logic [FTW_W-1:0] FTW_MIN  = 32'd42950,
    parameter logic [FTW_W-1:0] FTW_MAX  = 32'd429497,
    parameter logic [FTW_W-1:0] FTW_STEP = 32'd42950
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [FTW_W-1:0] ftw,
    output logic             step_pulse,
    output logic             dir
);

    typedef enum logic {
        TRI_UP = 1'b0,
        TRI_DN = 1'b1
    } tri_state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // Bounds held one bit wider so MIN+STEP and ftw+STEP can never wrap.
    localparam logic [FTW_W:0] MIN_X  = {1'b0, FTW_MIN};
    localparam logic [FTW_W:0] MAX_X  = {1'b0, FTW_MAX};
    localparam logic [FTW_W:0] STEP_X = {1'b0, FTW_STEP};
    localparam logic [FTW_W:0] LO_X   = MIN_X + STEP_X;

    logic             s1;
    logic             s2;
    logic             h;
    logic             ev;
    logic [1:0]       last_mode;
    tri_state_t       tri_state;
    tri_state_t       cur_state;
    logic [FTW_W:0]   ftw_x;
    logic [FTW_W:0]   sum;
    logic             out_of_range;

    always_comb begin
        ev           = s2 & ~h & en & ~rst;
        ftw_x        = {1'b0, ftw};
        sum          = ftw_x + STEP_X;
        out_of_range = (ftw_x < MIN_X) || (ftw_x > MAX_X);
        // A fresh entry into triangle mode always starts climbing.
        cur_state    = (last_mode != MODE_TRI) ? TRI_UP : tri_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            h          <= 1'b1;
            ftw        <= FTW_MIN;
            step_pulse <= 1'b0;
            dir        <= 1'b1;
            tri_state  <= TRI_UP;
            last_mode  <= MODE_HOLD;
        end else begin
            s1         <= tick_in;
            s2         <= s1;
            h          <= s2;
            step_pulse <= ev;
            if (ev) begin
                last_mode <= mode;
                if (out_of_range) begin
                    ftw <= FTW_MIN;
                end else begin
                    case (mode)
                        MODE_UP: begin
                            dir <= 1'b1;
                            if (sum > MAX_X) ftw <= FTW_MIN;
                            else             ftw <= sum[FTW_W-1:0];
                        end
                        MODE_DN: begin
                            dir <= 1'b0;
                            if (ftw_x < LO_X) ftw <= FTW_MAX;
                            else              ftw <= ftw - FTW_STEP;
                        end
                        MODE_TRI: begin
                            if (cur_state == TRI_UP) begin
                                if (sum >= MAX_X) begin
                                    ftw       <= FTW_MAX;
                                    tri_state <= TRI_DN;
                                    dir       <= 1'b0;
                                end else begin
                                    ftw       <= sum[FTW_W-1:0];
                                    tri_state <= TRI_UP;
                                    dir       <= 1'b1;
                                end
                            end else begin
                                if (ftw_x <= LO_X) begin
                                    ftw       <= FTW_MIN;
                                    tri_state <= TRI_UP;
                                    dir       <= 1'b1;
                                end else begin
                                    ftw       <= ftw - FTW_STEP;
                                    tri_state <= TRI_DN;
                                    dir       <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            ftw <= ftw;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: directed scenarios plus randomized edges, checked against
// an integer model of the sweep rules.
module tb_sweep_ctrl;

    localparam longint F_MIN  = 42950;
    localparam longint F_MAX  = 429497;
    localparam longint F_STEP = 42950;

    logic        clk;
    logic        rst;
    logic        tick_in;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] ftw;
    logic        step_pulse;
    logic        dir;

    int n_cmp = 0;
    int n_err = 0;

    longint m_ftw;
    bit     m_dir;
    bit     m_up;
    int     m_prev;

    sweep_ctrl dut (
        .clk(clk),
        .rst(rst),
        .tick_in(tick_in),
        .en(en),
        .mode(mode),
        .ftw(ftw),
        .step_pulse(step_pulse),
        .dir(dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ftw  = F_MIN;
        m_dir  = 1'b1;
        m_up   = 1'b1;
        m_prev = -1;
    endtask

    task automatic model_event(input logic [1:0] m);
        longint nxt;
        if (m_ftw < F_MIN || m_ftw > F_MAX) begin
            m_ftw = F_MIN;
        end else if (m == 2'd0) begin
            nxt   = m_ftw + F_STEP;
            m_ftw = (nxt > F_MAX) ? F_MIN : nxt;
            m_dir = 1'b1;
        end else if (m == 2'd1) begin
            nxt   = m_ftw - F_STEP;
            m_ftw = (nxt < F_MIN) ? F_MAX : nxt;
            m_dir = 1'b0;
        end else if (m == 2'd2) begin
            if (m_prev != 2) m_up = 1'b1;
            if (m_up) begin
                nxt = m_ftw + F_STEP;
                if (nxt >= F_MAX) begin m_ftw = F_MAX; m_up = 1'b0; end
                else m_ftw = nxt;
            end else begin
                nxt = m_ftw - F_STEP;
                if (nxt <= F_MIN) begin m_ftw = F_MIN; m_up = 1'b1; end
                else m_ftw = nxt;
            end
            m_dir = m_up;
        end
        m_prev = int'(m);
    endtask

    // One tick edge: strobe must appear only at the third sampled clock edge.
    task automatic do_edge(input logic [1:0] m, input logic e);
        @(negedge clk);
        mode    = m;
        en      = e;
        tick_in = 1'b1;
        if (e) model_event(m);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("step_pulse_e%0d", k), {31'd0, step_pulse}, {31'd0, (k == 2) && e});
        end
        check("ftw", ftw, 32'(m_ftw));
        check("dir", {31'd0, dir}, {31'd0, m_dir});
        @(negedge clk);
        tick_in = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge clk);
    endtask

    task automatic apply_reset(input logic tick_level);
        @(negedge clk);
        rst     = 1'b1;
        tick_in = tick_level;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst     = 1'b1;
        tick_in = 1'b1;
        en      = 1'b1;
        mode    = 2'b00;
        model_reset();

        // Reset released while tick_in is already high: no false step.
        apply_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("rst_release_step", {31'd0, step_pulse}, 32'd0);
        end
        check("rst_ftw", ftw, 32'd42950);
        check("rst_dir", {31'd0, dir}, 32'd1);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);

        // Up-wrap through the upper bound.
        for (int i = 0; i < 10; i++) do_edge(2'b00, 1'b1);

        // Triangle: climb to the clamp, then descend back to the minimum.
        apply_reset(1'b0);
        for (int i = 0; i < 20; i++) do_edge(2'b10, 1'b1);

        // Down-wrap from reset.
        apply_reset(1'b0);
        do_edge(2'b01, 1'b1);
        check("dn_first", ftw, 32'd429497);
        do_edge(2'b01, 1'b1);
        check("dn_second", ftw, 32'd386547);

        // Disabled edges are lost, then stepping resumes.
        for (int i = 0; i < 3; i++) do_edge(2'b00, 1'b0);
        do_edge(2'b00, 1'b1);

        // Reset asserted in the event cycle: the pending step is dropped.
        @(negedge clk);
        mode    = 2'b00;
        tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ev_step", {31'd0, step_pulse}, 32'd0);
        check("rst_ev_ftw", ftw, 32'd42950);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("rst_ev_after", {31'd0, step_pulse}, 32'd0);
        end
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized modes, enables and gaps, including mode changes mid-sweep.
        for (int i = 0; i < 60; i++) begin
            do_edge(2'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
